seg7_scanner: RTL



---
 rtl/seg7_pkg.sv | 34 +++
 rtl/hex_to_seg7.sv | 13 +
 rtl/seg7_scanner.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Purpose: shared constants and types for the seven-segment display blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg7_pkg;

    // All cathodes off (segments are active-low).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns, entry k is the glyph for hex digit k.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Purpose: 4-bit hex digit to active-low seven-segment pattern.
// Latency: combinational, zero cycles.
// Backpressure: none.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scanner.sv
// Purpose: time-multiplex N hex digits onto one active-low segment bus, stepping on refresh-clock rises.
// Latency: digit switch 3 i_clk edges after i_scanclk rises, then BLANK_CYCLES of all-anodes-off.
// Backpressure: none; free-running display, outputs hold on the current digit if the refresh clock stops.
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_scanclk,
    input  logic [4*N_DIGITS-1:0] i_value,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic                  i_blank_lz,
    output logic [N_DIGITS-1:0]   o_an,
    output logic [6:0]            o_seg,
    output logic                  o_dp
);

    localparam int IDX_W = $clog2(N_DIGITS);
    // Counter only has to reach BLANK_CYCLES-1.
    localparam int CNT_W = (BLANK_CYCLES > 2) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    logic                  scan_sync1;
    logic                  scan_sync2;
    logic                  scan_edge_q;
    logic                  tick;

    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic [4*N_DIGITS-1:0] snap_value;
    logic [4*N_DIGITS-1:0] snap_value_nxt;
    logic [N_DIGITS-1:0]   snap_dp;
    logic [N_DIGITS-1:0]   snap_dp_nxt;
    logic                  snap_blank_lz;
    logic                  snap_blank_lz_nxt;

    scan_state_t           state;
    logic [CNT_W-1:0]      blank_cnt;
    // Stays low after reset so the blank interval does not run out until a tick arrives.
    logic                  scan_started;

    logic [3:0]            digit_nxt;
    logic [4*N_DIGITS-1:0] upper_nxt;
    logic                  suppress_nxt;
    logic [6:0]            dec_seg;
    logic [N_DIGITS-1:0]   drive_an;
    logic [6:0]            drive_seg;
    logic                  drive_dp;

    // Two-flop synchroniser plus edge register for the asynchronous refresh clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scan_sync1  <= 1'b0;
            scan_sync2  <= 1'b0;
            scan_edge_q <= 1'b0;
        end else begin
            scan_sync1  <= i_scanclk;
            scan_sync2  <= scan_sync1;
            scan_edge_q <= scan_sync2;
        end
    end

    assign tick = scan_sync2 & ~scan_edge_q;

    // Next digit index, and a fresh snapshot only when the index wraps to digit 0.
    always_comb begin
        idx_nxt           = idx;
        snap_value_nxt    = snap_value;
        snap_dp_nxt       = snap_dp;
        snap_blank_lz_nxt = snap_blank_lz;
        if (tick) begin
            if (idx == IDX_LAST) begin
                idx_nxt           = '0;
                snap_value_nxt    = i_value;
                snap_dp_nxt       = i_dp;
                snap_blank_lz_nxt = i_blank_lz;
            end else begin
                idx_nxt = idx + IDX_W'(1);
            end
        end
    end

    // Index and frame snapshot registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx           <= '0;
            snap_value    <= '0;
            snap_dp       <= '0;
            snap_blank_lz <= 1'b0;
        end else begin
            idx           <= idx_nxt;
            snap_value    <= snap_value_nxt;
            snap_dp       <= snap_dp_nxt;
            snap_blank_lz <= snap_blank_lz_nxt;
        end
    end

    // Drive values come from the post-update index/snapshot so a zero-length blank shows the new digit at once.
    assign digit_nxt    = snap_value_nxt[{idx_nxt, 2'b00} +: 4];
    assign upper_nxt    = snap_value_nxt >> {idx_nxt, 2'b00};
    assign suppress_nxt = snap_blank_lz_nxt && (idx_nxt != '0) && (upper_nxt == '0);

    hex_to_seg7 u_hex_to_seg7 (
        .hex (digit_nxt),
        .seg (dec_seg)
    );

    assign drive_seg = suppress_nxt ? SEG_OFF : dec_seg;
    assign drive_an  = ~(N_DIGITS'(1) << idx_nxt);
    assign drive_dp  = ~snap_dp_nxt[idx_nxt];

    // Blank/drive sequencer with registered pin outputs; a tick always restarts the blank interval.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= BLANK;
            blank_cnt    <= '0;
            scan_started <= 1'b0;
            o_an         <= '1;
            o_seg        <= SEG_OFF;
            o_dp         <= 1'b1;
        end else if (tick) begin
            scan_started <= 1'b1;
            blank_cnt    <= '0;
            if (BLANK_CYCLES == 0) begin
                state <= DRIVE;
                o_an  <= drive_an;
                o_seg <= drive_seg;
                o_dp  <= drive_dp;
            end else begin
                state <= BLANK;
                o_an  <= '1;
                o_seg <= SEG_OFF;
                o_dp  <= 1'b1;
            end
        end else if (state == BLANK && scan_started) begin
            if (blank_cnt == CNT_LAST) begin
                state <= DRIVE;
                o_an  <= drive_an;
                o_seg <= drive_seg;
                o_dp  <= drive_dp;
            end else begin
                blank_cnt <= blank_cnt + CNT_W'(1);
            end
        end
    end

endmodule
